// File: rtl/multi_color_localizer_pkg.sv
// Shared widths and bounding-box result record for the multi-colour localizer.
`default_nettype none

package multi_color_localizer_pkg;

    localparam int BBOX_COORD_W = 16;
    localparam int BBOX_COUNT_W = 32;

    typedef struct packed {
        logic [BBOX_COUNT_W-1:0] hit_count;
        logic [BBOX_COORD_W-1:0] min_row;
        logic [BBOX_COORD_W-1:0] max_row;
        logic [BBOX_COORD_W-1:0] min_col;
        logic [BBOX_COORD_W-1:0] max_col;
        logic                    found;
    } bbox_result_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int row_width(input int height);
        return clog2_min1(height);
    endfunction

    function automatic int col_width(input int width);
        return clog2_min1(width);
    endfunction

    function automatic int count_width(input int width, input int height);
        return clog2_min1(width * height + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/chroma_window_match.sv
// One colour channel: combinational test of |U-Ut| <= Uth and |V-Vt| <= Vth.
`default_nettype none

module chroma_window_match #(
    parameter int YUV_WIDTH    = 9,
    parameter int THRESH_WIDTH = 7
) (
    input  logic signed [YUV_WIDTH-1:0]    u_i,
    input  logic signed [YUV_WIDTH-1:0]    v_i,
    input  logic signed [YUV_WIDTH-1:0]    u_target_i,
    input  logic signed [YUV_WIDTH-1:0]    v_target_i,
    input  logic        [THRESH_WIDTH-1:0] u_thresh_i,
    input  logic        [THRESH_WIDTH-1:0] v_thresh_i,
    output logic                           hit_o
);

    localparam int DW   = YUV_WIDTH + 1;
    localparam int CMPW = (DW > THRESH_WIDTH) ? DW : THRESH_WIDTH;

    logic signed [DW-1:0] du;
    logic signed [DW-1:0] dv;
    logic        [DW-1:0] du_abs;
    logic        [DW-1:0] dv_abs;

    // One extra bit holds any difference exactly, so the magnitude never wraps.
    assign du     = {u_i[YUV_WIDTH-1], u_i} - {u_target_i[YUV_WIDTH-1], u_target_i};
    assign dv     = {v_i[YUV_WIDTH-1], v_i} - {v_target_i[YUV_WIDTH-1], v_target_i};
    assign du_abs = du[DW-1] ? (~du + 1'b1) : du;
    assign dv_abs = dv[DW-1] ? (~dv + 1'b1) : dv;

    assign hit_o = (CMPW'(du_abs) <= CMPW'(u_thresh_i)) &&
                   (CMPW'(dv_abs) <= CMPW'(v_thresh_i));

endmodule

`default_nettype wire

// File: rtl/multi_color_localizer.sv
// Per-colour chroma mask plus per-frame bounding box and hit count.
`default_nettype none

module multi_color_localizer
    import multi_color_localizer_pkg::*;
#(
    parameter int NUM_COLORS   = 4,
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int YUV_WIDTH    = 9,
    parameter int THRESH_WIDTH = 7,
    parameter int MIN_PIXELS   = 16,
    localparam int RW = row_width(HEIGHT),
    localparam int CW = col_width(WIDTH),
    localparam int NW = count_width(WIDTH, HEIGHT)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    input  logic                               sof,
    input  logic signed [YUV_WIDTH-1:0]        U,
    input  logic signed [YUV_WIDTH-1:0]        V,
    input  logic [NUM_COLORS*YUV_WIDTH-1:0]    u_target,
    input  logic [NUM_COLORS*YUV_WIDTH-1:0]    v_target,
    input  logic [NUM_COLORS*THRESH_WIDTH-1:0] u_thresh,
    input  logic [NUM_COLORS*THRESH_WIDTH-1:0] v_thresh,
    output logic [NUM_COLORS-1:0]              mask_out,
    output logic                               mask_valid,
    output logic [NUM_COLORS*RW-1:0]           min_row,
    output logic [NUM_COLORS*RW-1:0]           max_row,
    output logic [NUM_COLORS*CW-1:0]           min_col,
    output logic [NUM_COLORS*CW-1:0]           max_col,
    output logic [NUM_COLORS*NW-1:0]           hit_count,
    output logic [NUM_COLORS-1:0]              found,
    output logic                               frame_done
);

    logic [RW-1:0] row_q, row_d, pix_row;
    logic [CW-1:0] col_q, col_d, pix_col;
    logic          first_px, last_px;

    logic [NUM_COLORS*YUV_WIDTH-1:0]    ut_q, vt_q, ut_eff, vt_eff;
    logic [NUM_COLORS*THRESH_WIDTH-1:0] uth_q, vth_q, uth_eff, vth_eff;

    logic [NUM_COLORS-1:0] hit;
    logic [NUM_COLORS-1:0] mask_q;
    logic                  mask_valid_q;
    logic                  frame_done_q;

    // A start-of-frame pixel is treated as (0,0) regardless of the counters.
    assign pix_row  = sof ? '0 : row_q;
    assign pix_col  = sof ? '0 : col_q;
    assign first_px = (pix_row == '0) && (pix_col == '0);
    assign last_px  = (pix_row == RW'(HEIGHT - 1)) && (pix_col == CW'(WIDTH - 1));

    // Pixel (0,0) compares against the live inputs, which are latched for the rest of the frame.
    assign ut_eff  = first_px ? u_target : ut_q;
    assign vt_eff  = first_px ? v_target : vt_q;
    assign uth_eff = first_px ? u_thresh : uth_q;
    assign vth_eff = first_px ? v_thresh : vth_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (in_valid) begin
            if (last_px) begin
                row_d = '0;
                col_d = '0;
            end else if (pix_col == CW'(WIDTH - 1)) begin
                row_d = pix_row + 1'b1;
                col_d = '0;
            end else begin
                row_d = pix_row;
                col_d = pix_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_q        <= '0;
            col_q        <= '0;
            mask_q       <= '0;
            mask_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            ut_q         <= '0;
            vt_q         <= '0;
            uth_q        <= '0;
            vth_q        <= '0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            mask_valid_q <= in_valid;
            frame_done_q <= in_valid && last_px;
            if (in_valid) begin
                mask_q <= hit;
            end
            if (in_valid && first_px) begin
                ut_q  <= u_target;
                vt_q  <= v_target;
                uth_q <= u_thresh;
                vth_q <= v_thresh;
            end
        end
    end

    assign mask_out   = mask_q;
    assign mask_valid = mask_valid_q;
    assign frame_done = frame_done_q;

    generate
        for (genvar k = 0; k < NUM_COLORS; k++) begin : g_ch
            logic [RW-1:0] min_row_q, min_row_d, max_row_q, max_row_d, base_min_row, base_max_row;
            logic [CW-1:0] min_col_q, min_col_d, max_col_q, max_col_d, base_min_col, base_max_col;
            logic [NW-1:0] cnt_q, cnt_d, base_cnt;
            bbox_result_t  res_q, res_d;
            logic          unused_res;

            chroma_window_match #(
                .YUV_WIDTH    (YUV_WIDTH),
                .THRESH_WIDTH (THRESH_WIDTH)
            ) u_match (
                .u_i        (U),
                .v_i        (V),
                .u_target_i (ut_eff[k*YUV_WIDTH +: YUV_WIDTH]),
                .v_target_i (vt_eff[k*YUV_WIDTH +: YUV_WIDTH]),
                .u_thresh_i (uth_eff[k*THRESH_WIDTH +: THRESH_WIDTH]),
                .v_thresh_i (vth_eff[k*THRESH_WIDTH +: THRESH_WIDTH]),
                .hit_o      (hit[k])
            );

            always_comb begin
                // A new frame (natural or sof-forced) starts from empty accumulators.
                base_min_row = first_px ? '1 : min_row_q;
                base_max_row = first_px ? '0 : max_row_q;
                base_min_col = first_px ? '1 : min_col_q;
                base_max_col = first_px ? '0 : max_col_q;
                base_cnt     = first_px ? '0 : cnt_q;

                min_row_d = base_min_row;
                max_row_d = base_max_row;
                min_col_d = base_min_col;
                max_col_d = base_max_col;
                cnt_d     = base_cnt;
                if (hit[k]) begin
                    if (pix_row < base_min_row) min_row_d = pix_row;
                    if (pix_row > base_max_row) max_row_d = pix_row;
                    if (pix_col < base_min_col) min_col_d = pix_col;
                    if (pix_col > base_max_col) max_col_d = pix_col;
                    if (base_cnt != '1)         cnt_d     = base_cnt + 1'b1;
                end

                res_d = '0;
                if (cnt_d != '0) begin
                    res_d.min_row   = BBOX_COORD_W'(min_row_d);
                    res_d.max_row   = BBOX_COORD_W'(max_row_d);
                    res_d.min_col   = BBOX_COORD_W'(min_col_d);
                    res_d.max_col   = BBOX_COORD_W'(max_col_d);
                    res_d.hit_count = BBOX_COUNT_W'(cnt_d);
                    res_d.found     = (BBOX_COUNT_W'(cnt_d) >= BBOX_COUNT_W'(MIN_PIXELS));
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    min_row_q <= '1;
                    max_row_q <= '0;
                    min_col_q <= '1;
                    max_col_q <= '0;
                    cnt_q     <= '0;
                    res_q     <= '0;
                end else if (in_valid) begin
                    if (last_px) begin
                        min_row_q <= '1;
                        max_row_q <= '0;
                        min_col_q <= '1;
                        max_col_q <= '0;
                        cnt_q     <= '0;
                        res_q     <= res_d;
                    end else begin
                        min_row_q <= min_row_d;
                        max_row_q <= max_row_d;
                        min_col_q <= min_col_d;
                        max_col_q <= max_col_d;
                        cnt_q     <= cnt_d;
                    end
                end
            end

            assign min_row[k*RW +: RW]   = res_q.min_row[RW-1:0];
            assign max_row[k*RW +: RW]   = res_q.max_row[RW-1:0];
            assign min_col[k*CW +: CW]   = res_q.min_col[CW-1:0];
            assign max_col[k*CW +: CW]   = res_q.max_col[CW-1:0];
            assign hit_count[k*NW +: NW] = res_q.hit_count[NW-1:0];
            assign found[k]              = res_q.found;
            assign unused_res            = ^res_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_color_localizer.sv
// Directed scoreboard bench for multi_color_localizer on an 8x4 frame with two channels.
`default_nettype none

module tb_multi_color_localizer;

    localparam int NC  = 2;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int YW  = 9;
    localparam int TW  = 7;
    localparam int MINP = 2;
    localparam int RW  = 2;
    localparam int CW  = 3;
    localparam int NW  = 6;

    typedef struct packed {
        logic [NC*RW-1:0] min_row;
        logic [NC*RW-1:0] max_row;
        logic [NC*CW-1:0] min_col;
        logic [NC*CW-1:0] max_col;
        logic [NC*NW-1:0] hit_count;
        logic [NC-1:0]    found;
    } frame_t;

    logic                 clk;
    logic                 reset_n;
    logic                 in_valid;
    logic                 sof;
    logic signed [YW-1:0] U;
    logic signed [YW-1:0] V;
    logic [NC*YW-1:0]     u_target, v_target;
    logic [NC*TW-1:0]     u_thresh, v_thresh;
    logic [NC-1:0]        mask_out;
    logic                 mask_valid;
    logic [NC*RW-1:0]     min_row, max_row;
    logic [NC*CW-1:0]     min_col, max_col;
    logic [NC*NW-1:0]     hit_count;
    logic [NC-1:0]        found;
    logic                 frame_done;

    multi_color_localizer #(
        .NUM_COLORS   (NC),
        .WIDTH        (W),
        .HEIGHT       (H),
        .YUV_WIDTH    (YW),
        .THRESH_WIDTH (TW),
        .MIN_PIXELS   (MINP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .sof        (sof),
        .U          (U),
        .V          (V),
        .u_target   (u_target),
        .v_target   (v_target),
        .u_thresh   (u_thresh),
        .v_thresh   (v_thresh),
        .mask_out   (mask_out),
        .mask_valid (mask_valid),
        .min_row    (min_row),
        .max_row    (max_row),
        .min_col    (min_col),
        .max_col    (max_col),
        .hit_count  (hit_count),
        .found      (found),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [NC-1:0] mq[$];
    frame_t        fq[$];

    int tgt_u[NC], tgt_v[NC], tgt_thu[NC], tgt_thv[NC];
    int l_tu[NC],  l_tv[NC],  l_thu[NC],   l_thv[NC];
    int a_mnr[NC], a_mxr[NC], a_mnc[NC], a_mxc[NC], a_cnt[NC];
    int m_row, m_col;
    int hits[$];
    int nears[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic bit is_hit(input int p);
        foreach (hits[i]) if (hits[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_near(input int p);
        foreach (nears[i]) if (nears[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_acc();
        for (int k = 0; k < NC; k++) begin
            a_mnr[k] = 1000; a_mxr[k] = -1; a_mnc[k] = 1000; a_mxc[k] = -1; a_cnt[k] = 0;
        end
    endtask

    task automatic set_tgt(input int k, input int tu, input int tv, input int thu, input int thv);
        tgt_u[k] = tu; tgt_v[k] = tv; tgt_thu[k] = thu; tgt_thv[k] = thv;
        u_target[k*YW +: YW] = tu[YW-1:0];
        v_target[k*YW +: YW] = tv[YW-1:0];
        u_thresh[k*TW +: TW] = thu[TW-1:0];
        v_thresh[k*TW +: TW] = thv[TW-1:0];
    endtask

    task automatic idle();
        in_valid = 1'b0;
        sof      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel and let the reference model predict its mask and any frame result.
    task automatic pix(input int u, input int v, input bit s);
        logic [NC-1:0] em;
        frame_t        ef;
        U        = u[YW-1:0];
        V        = v[YW-1:0];
        sof      = s;
        in_valid = 1'b1;
        if (s) begin
            m_row = 0;
            m_col = 0;
        end
        if (m_row == 0 && m_col == 0) begin
            for (int k = 0; k < NC; k++) begin
                l_tu[k] = tgt_u[k]; l_tv[k] = tgt_v[k]; l_thu[k] = tgt_thu[k]; l_thv[k] = tgt_thv[k];
            end
            clear_acc();
        end
        for (int k = 0; k < NC; k++) begin
            em[k] = (iabs(u - l_tu[k]) <= l_thu[k]) && (iabs(v - l_tv[k]) <= l_thv[k]);
            if (em[k]) begin
                if (m_row < a_mnr[k]) a_mnr[k] = m_row;
                if (m_row > a_mxr[k]) a_mxr[k] = m_row;
                if (m_col < a_mnc[k]) a_mnc[k] = m_col;
                if (m_col > a_mxc[k]) a_mxc[k] = m_col;
                a_cnt[k]++;
            end
        end
        mq.push_back(em);
        if (m_row == H - 1 && m_col == W - 1) begin
            ef = '0;
            for (int k = 0; k < NC; k++) begin
                if (a_cnt[k] != 0) begin
                    ef.min_row[k*RW +: RW]   = a_mnr[k][RW-1:0];
                    ef.max_row[k*RW +: RW]   = a_mxr[k][RW-1:0];
                    ef.min_col[k*CW +: CW]   = a_mnc[k][CW-1:0];
                    ef.max_col[k*CW +: CW]   = a_mxc[k][CW-1:0];
                    ef.hit_count[k*NW +: NW] = a_cnt[k][NW-1:0];
                    ef.found[k]              = (a_cnt[k] >= MINP);
                end
            end
            fq.push_back(ef);
            clear_acc();
            m_row = 0;
            m_col = 0;
        end else if (m_col == W - 1) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic run_px(input int n, input bit sof_first, input bit toggle, input int chg_at);
        for (int i = 0; i < n; i++) begin
            bit s;
            int p;
            s = sof_first && (i == 0);
            p = s ? 0 : m_row * W + m_col;
            if (i == chg_at) begin
                set_tgt(0, 50, 50, 5, 5);
                set_tgt(1, 50, 50, 3, 3);
            end
            if (toggle) idle();
            if (is_hit(p))       pix(-21, 5, s);
            else if (is_near(p)) pix(-32, 0, s);
            else                 pix(50, 50, s);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mask_valid"}, mask_valid, 0);
        check({tag, "_mask_out"},   mask_out,   0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_min_row"},    min_row,    0);
        check({tag, "_max_row"},    max_row,    0);
        check({tag, "_min_col"},    min_col,    0);
        check({tag, "_max_col"},    max_col,    0);
        check({tag, "_hit_count"},  hit_count,  0);
        check({tag, "_found"},      found,      0);
    endtask

    task automatic reset_dut();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_row = 0;
        m_col = 0;
        clear_acc();
    endtask

    task automatic check_frame(input string tag, input logic [3:0] mnr, input logic [3:0] mxr,
                               input logic [5:0] mnc, input logic [5:0] mxc,
                               input logic [11:0] cnt, input logic [1:0] fnd);
        check({tag, "_frame_done"}, frame_done, 1);
        check({tag, "_min_row"},    min_row,    mnr);
        check({tag, "_max_row"},    max_row,    mxr);
        check({tag, "_min_col"},    min_col,    mnc);
        check({tag, "_max_col"},    max_col,    mxc);
        check({tag, "_hit_count"},  hit_count,  cnt);
        check({tag, "_found"},      found,      fnd);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mask_valid) begin
                if (mq.size() == 0) begin
                    check("mask_unexpected", 1, 0);
                end else begin
                    logic [NC-1:0] em;
                    em = mq.pop_front();
                    check("mask", mask_out, em);
                end
            end
            if (frame_done) begin
                if (fq.size() == 0) begin
                    check("frame_done_unexpected", 1, 0);
                end else begin
                    frame_t ef;
                    ef = fq.pop_front();
                    check("sb_min_row",   min_row,   ef.min_row);
                    check("sb_max_row",   max_row,   ef.max_row);
                    check("sb_min_col",   min_col,   ef.min_col);
                    check("sb_max_col",   max_col,   ef.max_col);
                    check("sb_hit_count", hit_count, ef.hit_count);
                    check("sb_found",     found,     ef.found);
                end
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        sof      = 1'b0;
        U        = '0;
        V        = '0;
        u_target = '0;
        v_target = '0;
        u_thresh = '0;
        v_thresh = '0;
        set_tgt(0, -26, 0, 5, 5);
        set_tgt(1, 100, 100, 3, 3);
        m_row = 0;
        m_col = 0;
        clear_acc();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_zero("reset");

        // Edge-inclusive hit at (1,2), one-beyond miss at (0,1), second hit at (3,6).
        hits  = '{10, 30};
        nears = '{1};
        run_px(32, 1'b1, 1'b0, -1);
        check_frame("frameA", 4'b0001, 4'b0011, 6'o02, 6'o06, 12'd2, 2'b01);
        idle();
        check("frame_done_pulse", frame_done, 0);

        // Lone hit on the very last pixel.
        hits  = '{31};
        nears.delete();
        run_px(32, 1'b0, 1'b0, -1);
        check_frame("frameB", 4'b0011, 4'b0011, 6'o07, 6'o07, 12'd1, 2'b00);

        // Abort after 20 pixels with sof; the earlier hits must vanish.
        hits = '{3, 9};
        run_px(20, 1'b0, 1'b0, -1);
        check("abort_no_done", frame_done, 0);
        hits = '{18};
        run_px(31, 1'b1, 1'b0, -1);
        check("abort_not_yet_done", frame_done, 0);
        run_px(1, 1'b0, 1'b0, -1);
        check_frame("frameC", 4'b0010, 4'b0010, 6'o02, 6'o02, 12'd1, 2'b00);

        // Continuous reference frame, then the same data with gaps and a mid-frame target change.
        hits = '{0, 15, 21};
        run_px(32, 1'b0, 1'b0, -1);
        check_frame("frameD1", 4'b0000, 4'b0010, 6'o00, 6'o07, 12'd3, 2'b01);
        run_px(32, 1'b0, 1'b1, 10);
        check_frame("frameD2", 4'b0000, 4'b0010, 6'o00, 6'o07, 12'd3, 2'b01);
        set_tgt(0, -26, 0, 5, 5);
        set_tgt(1, 100, 100, 3, 3);

        // Reset part-way through a frame, then a clean frame.
        hits  = '{10, 30};
        nears = '{1};
        run_px(12, 1'b0, 1'b0, -1);
        reset_dut();
        check_zero("midreset");
        run_px(32, 1'b0, 1'b0, -1);
        check_frame("frameE", 4'b0001, 4'b0011, 6'o02, 6'o06, 12'd2, 2'b01);

        repeat (3) idle();
        check("mask_queue_drained",  mq.size(), 0);
        check("frame_queue_drained", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_color_localizer.md
MULTI_COLOR_LOCALIZER -- requirements
Module: multi_color_localizer

Interface
REQ-001 SHALL have parameter NUM_COLORS, default 4, number of independent colour channels.
REQ-002 SHALL have parameter WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-004 SHALL have parameter YUV_WIDTH, default 9, signed U/V width.
REQ-005 SHALL have parameter THRESH_WIDTH, default 7, unsigned threshold width.
REQ-006 SHALL have parameter MIN_PIXELS, default 16, minimum hit count for found.
REQ-007 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-008 SHALL have reset_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have in_valid  input  1  pixel strobe.
REQ-010 SHALL have sof  input  1  start of frame, qualified by in_valid.
REQ-011 SHALL have U, V  input  YUV_WIDTH each  signed chroma.
REQ-012 SHALL have u_target, v_target  input  NUM_COLORS*YUV_WIDTH  packed signed targets, channel k at slice k.
REQ-013 SHALL have u_thresh, v_thresh  input  NUM_COLORS*THRESH_WIDTH  packed unsigned thresholds.
REQ-014 SHALL have mask_out  output  NUM_COLORS  per-channel hit, bit k = channel k.
REQ-015 SHALL have mask_valid  output  1  qualifies mask_out.
REQ-016 SHALL have min_row, max_row  output  NUM_COLORS*RW  packed; RW = clog2(HEIGHT).
REQ-017 SHALL have min_col, max_col  output  NUM_COLORS*CW  packed; CW = clog2(WIDTH).
REQ-018 SHALL have hit_count  output  NUM_COLORS*NW  packed; NW = clog2(WIDTH*HEIGHT+1).
REQ-019 SHALL have found  output  NUM_COLORS  hit_count >= MIN_PIXELS.
REQ-020 SHALL have frame_done  output  1  one-cycle pulse; results updated.

Function
REQ-021 Channel k SHALL hit when |U-u_target_k| <= u_thresh_k AND |V-v_target_k| <= v_thresh_k, differences in YUV_WIDTH+1 signed bits, no saturation.
REQ-022 Channels SHALL be independent; multiple bits of mask_out may be set.
REQ-023 mask_out/mask_valid SHALL be registered, 1-cycle latency from in_valid; mask_valid = delayed in_valid.
REQ-024 Internal col/row counters SHALL advance only on in_valid; col wraps WIDTH-1 -> 0 incrementing row; row wraps HEIGHT-1 -> 0.
REQ-025 sof with in_valid SHALL force that pixel to (0,0), discard partial accumulators, no frame_done for the aborted frame.
REQ-026 Targets/thresholds SHALL be latched at pixel (0,0) and held for the whole frame; mid-frame changes ignored.
REQ-027 Per channel, each hit SHALL update min/max row/col and increment count (saturating at all ones).
REQ-028 On the last pixel (HEIGHT-1, WIDTH-1) the pixel SHALL be included, results copied to outputs, accumulators cleared, frame_done asserted next cycle for exactly 1 cycle.
REQ-029 Channel with zero hits SHALL report min = max = 0, hit_count 0, found 0.
REQ-030 Result outputs SHALL hold until the next frame_done.
REQ-031 in_valid low SHALL stall everything; no state change except mask_valid falling.

Reset
REQ-032 reset_n low SHALL clear counters, accumulators, all outputs to 0 (min accumulators to all ones internally); next in_valid pixel is (0,0).
REQ-033 Reset mid-frame SHALL discard the frame without frame_done.

Structure
REQ-034 Shared package SHALL hold the RW/CW/NW width functions and the bounding-box result struct.
REQ-035 One sub-module chroma_window_match (one channel, combinational compare) SHALL be instantiated NUM_COLORS times via generate.

Verification (bench params WIDTH=8, HEIGHT=4, NUM_COLORS=2, MIN_PIXELS=2)
REQ-036 Ch0 target (-26,0) thresh (5,5); U=-21,V=5 -> mask_out[0]=1; U=-32 -> 0 (edge inclusive, one beyond excluded).
REQ-037 Hits for ch0 at (1,2),(3,6) only -> frame_done once; min_row 1, max_row 3, min_col 2, max_col 6, hit_count 2, found[0]=1; ch1 all zero, found[1]=0.
REQ-038 Single hit at last pixel (3,7) -> min=max=(3,7), hit_count 1, found 0.
REQ-039 sof asserted at pixel 20 of frame -> no frame_done until 32 further valid pixels; earlier hits absent.
REQ-040 in_valid toggling 50% with target change mid-frame -> results identical to continuous-valid run with original targets.
REQ-041 reset_n low mid-frame -> outputs 0, no frame_done; next full frame reports correctly.
